// File: rtl/ajit_accel_dma_regfile.sv
// AJIT accelerator register file on the AFB slave pipes, with a 64-bit word
// copy/fill engine on the ACB master pipes and a level completion interrupt.
module ajit_accel_dma_regfile #(
  parameter int unsigned NUM_REGS      = 16,
  parameter bit          STRICT_DECODE = 1'b1,
  parameter int unsigned LEN_W         = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         AFB_ACCELERATOR_REQUEST_pipe_write_req,
  output logic         AFB_ACCELERATOR_REQUEST_pipe_write_ack,
  input  logic [73:0]  AFB_ACCELERATOR_REQUEST_pipe_write_data,
  output logic [32:0]  AFB_ACCELERATOR_RESPONSE_pipe_read_data,
  input  logic         AFB_ACCELERATOR_RESPONSE_pipe_read_req,
  output logic         AFB_ACCELERATOR_RESPONSE_pipe_read_ack,
  output logic [109:0] ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data,
  input  logic         ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
  output logic         ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack,
  input  logic [64:0]  ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data,
  input  logic         ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req,
  output logic         ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack,
  output logic         ACCELERATOR_INTERRUPT
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  localparam logic [IDX_W-1:0] IdxCtrl     = IDX_W'(0);
  localparam logic [IDX_W-1:0] IdxStatus   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IdxSrc      = IDX_W'(2);
  localparam logic [IDX_W-1:0] IdxDst      = IDX_W'(3);
  localparam logic [IDX_W-1:0] IdxLen      = IDX_W'(4);
  localparam logic [IDX_W-1:0] IdxFillLo   = IDX_W'(5);
  localparam logic [IDX_W-1:0] IdxFillHi   = IDX_W'(6);
  localparam logic [IDX_W-1:0] IdxProgress = IDX_W'(7);

  typedef enum logic [1:0] {AIdle, AExec, AResp} afb_state_t;
  typedef enum logic [2:0] {EIdle, ERdReq, ERdWait, EWrReq, EWrWait, EDone} eng_state_t;

  afb_state_t a_state;
  eng_state_t e_state;

  logic        afb_wack_q, afb_rack_q;
  logic [32:0] afb_resp_q;
  logic        req_rd_q;
  logic [3:0]  req_mask_q;
  logic [35:2] req_addr_q;
  logic [31:0] req_wdata_q;

  logic [31:0] regs [NUM_REGS];
  logic        busy_q, done_q, error_q, irq_q;
  logic [LEN_W-1:0] progress_q, job_len_q;
  logic [35:0] job_src_q, job_dst_q;
  logic [63:0] job_fill_q;
  logic        job_fill_mode_q;

  logic         mreq_vld_q, mresp_ack_q;
  logic [109:0] mreq_data_q;

  logic [IDX_W-1:0] req_idx;
  logic             dec_err, wr_commit, start_fire, w1c_done, w1c_err;
  logic             done_set, err_set, mreq_fire, mresp_fire;
  logic [31:0]      wr_bmask, wr_merged, ctrl_merged, rd_val;
  logic [LEN_W-1:0] progress_next, start_len;
  logic [35:0]      start_src, start_dst;

  assign req_idx    = req_addr_q[IDX_W+1:2];
  assign dec_err    = STRICT_DECODE && (req_addr_q[35:IDX_W+2] != '0);
  assign wr_commit  = (a_state == AExec) && !req_rd_q && !dec_err;
  assign start_fire = wr_commit && (req_idx == IdxCtrl) && req_mask_q[0] && req_wdata_q[0] &&
                      (e_state == EIdle);
  assign w1c_done   = wr_commit && (req_idx == IdxStatus) && req_mask_q[0] && req_wdata_q[1];
  assign w1c_err    = wr_commit && (req_idx == IdxStatus) && req_mask_q[0] && req_wdata_q[2];

  always_comb begin
    wr_bmask = '0;
    for (int i = 0; i < 4; i++) wr_bmask[8*i +: 8] = {8{req_mask_q[i]}};
  end

  assign wr_merged   = (regs[req_idx] & ~wr_bmask) | (req_wdata_q & wr_bmask);
  assign ctrl_merged = (regs[IdxCtrl] & ~wr_bmask) | (req_wdata_q & wr_bmask);

  always_comb begin
    rd_val = regs[req_idx];
    if (req_idx == IdxCtrl)     rd_val = {regs[IdxCtrl][31:1], 1'b0};
    if (req_idx == IdxStatus)   rd_val = {29'b0, error_q, done_q, busy_q};
    if (req_idx == IdxProgress) rd_val = 32'(progress_q);
  end

  // AFB slave: accept, execute for one cycle, then hold the response until taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_state     <= AIdle;
      afb_wack_q  <= 1'b0;
      afb_rack_q  <= 1'b0;
      afb_resp_q  <= '0;
      req_rd_q    <= 1'b0;
      req_mask_q  <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else begin
      unique case (a_state)
        AIdle: begin
          afb_wack_q <= 1'b1;
          if (afb_wack_q && AFB_ACCELERATOR_REQUEST_pipe_write_req) begin
            req_rd_q    <= AFB_ACCELERATOR_REQUEST_pipe_write_data[72];
            req_mask_q  <= AFB_ACCELERATOR_REQUEST_pipe_write_data[71:68];
            req_addr_q  <= AFB_ACCELERATOR_REQUEST_pipe_write_data[67:34];
            req_wdata_q <= AFB_ACCELERATOR_REQUEST_pipe_write_data[31:0];
            afb_wack_q  <= 1'b0;
            a_state     <= AExec;
          end
        end
        AExec: begin
          afb_rack_q <= 1'b1;
          if (dec_err)       afb_resp_q <= {1'b1, 32'h0};
          else if (req_rd_q) afb_resp_q <= {1'b0, rd_val};
          else               afb_resp_q <= '0;
          a_state <= AResp;
        end
        AResp: begin
          if (afb_rack_q && AFB_ACCELERATOR_RESPONSE_pipe_read_req) begin
            afb_rack_q <= 1'b0;
            afb_resp_q <= '0;
            afb_wack_q <= 1'b1;
            a_state    <= AIdle;
          end
        end
        default: a_state <= AIdle;
      endcase
    end
  end

  // STATUS and PROGRESS are owned elsewhere, so their slots in the array stay unwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_commit && (req_idx != IdxStatus) && (req_idx != IdxProgress)) begin
      regs[req_idx] <= wr_merged;
    end
  end

  assign mreq_fire  = mreq_vld_q && ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req;
  assign mresp_fire = mresp_ack_q && ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req;
  assign done_set   = (e_state == EDone);
  assign err_set    = mresp_fire && ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data[64] &&
                      ((e_state == ERdWait) || (e_state == EWrWait));

  // Engine set takes priority over a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (start_fire)               busy_q <= 1'b1;
      else if (done_set || err_set) busy_q <= 1'b0;
      done_q  <= done_set | (done_q & ~w1c_done);
      error_q <= err_set | (error_q & ~w1c_err);
      irq_q   <= regs[IdxCtrl][1] & (done_q | error_q);
    end
  end

  function automatic logic [35:0] word_addr(input logic [35:0] base, input logic [LEN_W-1:0] k);
    return base + 36'({k, 3'b000});
  endfunction

  function automatic logic [109:0] rd_pkt(input logic [35:0] addr);
    return {1'b0, 1'b1, 8'hFF, addr, 64'h0};
  endfunction

  function automatic logic [109:0] wr_pkt(input logic [35:0] addr, input logic [63:0] data);
    return {1'b0, 1'b0, 8'hFF, addr, data};
  endfunction

  assign progress_next = progress_q + LEN_W'(1);
  assign start_len     = regs[IdxLen][LEN_W-1:0];
  assign start_src     = {4'b0, regs[IdxSrc][31:3], 3'b000};
  assign start_dst     = {4'b0, regs[IdxDst][31:3], 3'b000};

  always_ff @(posedge clk) begin
    if (reset) begin
      e_state         <= EIdle;
      mreq_vld_q      <= 1'b0;
      mreq_data_q     <= '0;
      mresp_ack_q     <= 1'b0;
      progress_q      <= '0;
      job_len_q       <= '0;
      job_src_q       <= '0;
      job_dst_q       <= '0;
      job_fill_q      <= '0;
      job_fill_mode_q <= 1'b0;
    end else begin
      unique case (e_state)
        EIdle: begin
          mresp_ack_q <= 1'b1;
          if (start_fire) begin
            job_src_q       <= start_src;
            job_dst_q       <= start_dst;
            job_len_q       <= start_len;
            job_fill_mode_q <= ctrl_merged[2];
            job_fill_q      <= {regs[IdxFillHi], regs[IdxFillLo]};
            progress_q      <= '0;
            mresp_ack_q     <= 1'b0;
            if (start_len == '0) begin
              e_state <= EDone;
            end else if (ctrl_merged[2]) begin
              mreq_vld_q  <= 1'b1;
              mreq_data_q <= wr_pkt(start_dst, {regs[IdxFillHi], regs[IdxFillLo]});
              e_state     <= EWrReq;
            end else begin
              mreq_vld_q  <= 1'b1;
              mreq_data_q <= rd_pkt(start_src);
              e_state     <= ERdReq;
            end
          end
        end
        ERdReq, EWrReq: begin
          if (mreq_fire) begin
            mreq_vld_q  <= 1'b0;
            mresp_ack_q <= 1'b1;
            e_state     <= (e_state == ERdReq) ? ERdWait : EWrWait;
          end
        end
        ERdWait: begin
          if (mresp_fire) begin
            if (ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data[64]) begin
              e_state <= EIdle;
            end else begin
              mresp_ack_q <= 1'b0;
              mreq_vld_q  <= 1'b1;
              mreq_data_q <= wr_pkt(word_addr(job_dst_q, progress_q),
                                    ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data[63:0]);
              e_state     <= EWrReq;
            end
          end
        end
        EWrWait: begin
          if (mresp_fire) begin
            if (ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data[64]) begin
              e_state <= EIdle;
            end else begin
              progress_q  <= progress_next;
              mresp_ack_q <= 1'b0;
              if (progress_next == job_len_q) begin
                e_state <= EDone;
              end else if (job_fill_mode_q) begin
                mreq_vld_q  <= 1'b1;
                mreq_data_q <= wr_pkt(word_addr(job_dst_q, progress_next), job_fill_q);
                e_state     <= EWrReq;
              end else begin
                mreq_vld_q  <= 1'b1;
                mreq_data_q <= rd_pkt(word_addr(job_src_q, progress_next));
                e_state     <= ERdReq;
              end
            end
          end
        end
        EDone: begin
          mresp_ack_q <= 1'b1;
          e_state     <= EIdle;
        end
        default: e_state <= EIdle;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{AFB_ACCELERATOR_REQUEST_pipe_write_data[73],
                         AFB_ACCELERATOR_REQUEST_pipe_write_data[33:32], req_addr_q};

  assign AFB_ACCELERATOR_REQUEST_pipe_write_ack      = afb_wack_q;
  assign AFB_ACCELERATOR_RESPONSE_pipe_read_ack      = afb_rack_q;
  assign AFB_ACCELERATOR_RESPONSE_pipe_read_data     = afb_resp_q;
  assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack   = mreq_vld_q;
  assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data  = mreq_data_q;
  assign ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack = mresp_ack_q;
  assign ACCELERATOR_INTERRUPT                       = irq_q;

endmodule

// File: tb/tb_ajit_accel_dma_regfile.sv
// Bench for ajit_accel_dma_regfile: AFB register traffic plus a behavioural ACB
// memory that logs every request against an expected transaction list.
module tb_ajit_accel_dma_regfile;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         afb_req = 1'b0, afb_ack;
  logic [73:0]  afb_data = '0;
  logic [32:0]  rsp_data;
  logic         rsp_rdy = 1'b0, rsp_vld;
  logic [109:0] mreq_data;
  logic         mreq_rdy, mreq_vld;
  logic [64:0]  mresp_data;
  logic         mresp_vld, mresp_ack;
  logic         irq;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic        rd;
    logic [35:0] addr;
    logic [63:0] data;
  } mtxn_t;

  mtxn_t       req_log[$];
  mtxn_t       exp_q[$];
  logic [63:0] mem [logic [35:0]];
  int          mem_stall = 0;
  int          err_at = -1;
  bit          hold_wr = 1'b0;
  bit          stray_req = 1'b0;
  logic [31:0] mdl [16];

  always #5 clk = ~clk;

  ajit_accel_dma_regfile #(.NUM_REGS(16), .STRICT_DECODE(1'b1), .LEN_W(16)) dut (
    .clk                                         (clk),
    .reset                                       (reset),
    .AFB_ACCELERATOR_REQUEST_pipe_write_req      (afb_req),
    .AFB_ACCELERATOR_REQUEST_pipe_write_ack      (afb_ack),
    .AFB_ACCELERATOR_REQUEST_pipe_write_data     (afb_data),
    .AFB_ACCELERATOR_RESPONSE_pipe_read_data     (rsp_data),
    .AFB_ACCELERATOR_RESPONSE_pipe_read_req      (rsp_rdy),
    .AFB_ACCELERATOR_RESPONSE_pipe_read_ack      (rsp_vld),
    .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data  (mreq_data),
    .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req   (mreq_rdy),
    .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack   (mreq_vld),
    .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data(mresp_data),
    .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req (mresp_vld),
    .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack (mresp_ack),
    .ACCELERATOR_INTERRUPT                       (irq)
  );

  function automatic logic [63:0] mem_rd(input logic [35:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[31:0], ~a[31:0]};
  endfunction

  // Memory model: stalls each request, checks it is held, logs it, then responds.
  initial begin : responder
    mtxn_t t;
    logic [109:0] snap;
    bit stable;
    int n;
    mreq_rdy = 1'b0;
    mresp_vld = 1'b0;
    mresp_data = '0;
    forever begin
      @(negedge clk);
      if (stray_req) begin
        mresp_data = {1'b0, 64'hA5A5_0000_5A5A_FFFF};
        mresp_vld = 1'b1;
        n = 0;
        while (!mresp_ack && n < 20) begin @(negedge clk); n++; end
        total++;
        if (mresp_ack !== 1'b1) $display("FAIL stray_ack: ack=%b required=1", mresp_ack);
        else passed++;
        @(negedge clk);
        mresp_vld = 1'b0;
        stray_req = 1'b0;
      end else if (mreq_vld && !reset) begin
        snap = mreq_data;
        t = '{rd: snap[108], addr: snap[99:64], data: snap[63:0]};
        stable = 1'b1;
        for (int s = 0; s < mem_stall; s++) begin
          @(negedge clk);
          if (mreq_data !== snap || mreq_vld !== 1'b1) stable = 1'b0;
        end
        mreq_rdy = 1'b1;
        @(negedge clk);
        mreq_rdy = 1'b0;
        req_log.push_back(t);
        total++;
        if (!stable || snap[109] !== 1'b0 || snap[107:100] !== 8'hFF)
          $display("FAIL req_hold: stable=%b lock=%b mask=%h required stable=1 lock=0 mask=ff",
                   stable, snap[109], snap[107:100]);
        else passed++;
        if (!t.rd) mem[t.addr] = t.data;
        if (!(hold_wr && !t.rd)) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          mresp_data = {(int'(req_log.size()) - 1 == err_at), t.rd ? mem_rd(t.addr) : 64'h0};
          mresp_vld = 1'b1;
          n = 0;
          while (!mresp_ack && n < 50) begin @(negedge clk); n++; end
          if (!mresp_ack) begin
            total++;
            $display("FAIL resp_ack_timeout: ack=%b required=1", mresp_ack);
          end
          @(negedge clk);
          mresp_vld = 1'b0;
        end
      end
    end
  end

  task automatic afb(input bit rd, input logic [3:0] m, input logic [35:0] a,
                     input logic [31:0] d, input int rstall,
                     output logic [32:0] r, output int lat, output bit held);
    int n = 0;
    held = 1'b1;
    r = 'x;
    lat = -1;
    @(negedge clk);
    afb_data = {1'b0, rd, m, a, d};
    afb_req = 1'b1;
    while (!afb_ack && n < 50) begin @(negedge clk); n++; end
    if (!afb_ack) begin
      total++;
      $display("FAIL afb_accept_timeout: ack=%b required=1", afb_ack);
      afb_req = 1'b0;
      return;
    end
    @(negedge clk);
    afb_req = 1'b0;
    lat = 1;
    while (!rsp_vld && lat < 50) begin @(negedge clk); lat++; end
    if (!rsp_vld) begin
      total++;
      $display("FAIL afb_resp_timeout: valid=%b required=1", rsp_vld);
      return;
    end
    r = rsp_data;
    repeat (rstall) begin
      @(negedge clk);
      if (rsp_data !== r || rsp_vld !== 1'b1) held = 1'b0;
    end
    rsp_rdy = 1'b1;
    @(negedge clk);
    rsp_rdy = 1'b0;
  endtask

  task automatic reg_wr(input int idx, input logic [31:0] d, input logic [3:0] m = 4'hF);
    logic [32:0] r;
    int l;
    bit h;
    afb(1'b0, m, 36'(idx * 4), d, 0, r, l, h);
  endtask

  task automatic reg_rd(input int idx, output logic [31:0] d);
    logic [32:0] r;
    int l;
    bit h;
    afb(1'b1, 4'hF, 36'(idx * 4), 32'h0, 0, r, l, h);
    d = r[31:0];
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    int n = 0;
    do begin reg_rd(1, s); n++; end while (s[0] !== 1'b0 && n < 100);
    if (s[0] !== 1'b0) begin
      total++;
      $display("FAIL wait_idle: busy=%b required=0 after %0d polls", s[0], n);
    end
  endtask

  // Reference: the ACB traffic a job must produce, from the register contents.
  task automatic build_exp(input logic [31:0] src, input logic [31:0] dst, input int len,
                           input bit fill, input logic [63:0] pat);
    logic [35:0] sb, db;
    sb = {4'h0, src & 32'hFFFF_FFF8};
    db = {4'h0, dst & 32'hFFFF_FFF8};
    exp_q.delete();
    for (int k = 0; k < len; k++) begin
      if (!fill) exp_q.push_back('{rd: 1'b1, addr: sb + 36'(8 * k), data: 64'h0});
      exp_q.push_back('{rd: 1'b0, addr: db + 36'(8 * k),
                        data: fill ? pat : mem_rd(sb + 36'(8 * k))});
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({afb_ack, rsp_vld, rsp_data, mreq_vld, mreq_data, mresp_ack, irq} !== '0)
      $display("FAIL reset_outputs: ack=%b rvld=%b rdata=%h mvld=%b mdata=%h mrack=%b irq=%b required all 0",
               afb_ack, rsp_vld, rsp_data, mreq_vld, mreq_data, mresp_ack, irq);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({afb_ack, mresp_ack} !== 2'b11)
      $display("FAIL idle_acks: afb_ack=%b mresp_ack=%b required 1 1", afb_ack, mresp_ack);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      reg_rd(i, v);
      mdl[i] = 32'h0;
      total++;
      if (v !== 32'h0) $display("FAIL reset_reg%0d: got=%h required=0", i, v);
      else passed++;
    end
  endtask

  task automatic test_regfile();
    logic [32:0] r;
    logic [31:0] v, d, bm;
    int lat, idx;
    bit held;
    logic [3:0] m;
    reg_wr(9, 32'hDEADBEEF, 4'hF);
    reg_wr(9, 32'h0000AA00, 4'b0010);
    afb(1'b1, 4'hF, 36'h24, 32'h0, 5, r, lat, held);
    mdl[9] = 32'hDEADAAEF;
    total++;
    if (r !== {1'b0, 32'hDEADAAEF}) $display("FAIL masked_write: got=%h required=0deadaaef", r);
    else passed++;
    total++;
    if (lat != 2) $display("FAIL afb_latency: got=%0d required=2", lat);
    else passed++;
    total++;
    if (!held) $display("FAIL resp_held: held=%b required=1", held);
    else passed++;
    reg_wr(0, 32'hA5A5_5A56);
    reg_rd(0, v);
    total++;
    if (v !== 32'hA5A5_5A56) $display("FAIL ctrl_rw: got=%h required=a5a55a56", v);
    else passed++;
    reg_wr(0, 32'h0);
    // Random byte-masked writes to everything except CTRL; STATUS/PROGRESS must not move.
    for (int it = 0; it < 24; it++) begin
      idx = $urandom_range(1, 15);
      d = $urandom;
      m = 4'($urandom);
      if (idx == 1) d[0] = 1'b1;
      reg_wr(idx, d, m);
      bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
      if (idx != 1 && idx != 7) mdl[idx] = (mdl[idx] & ~bm) | (d & bm);
      idx = $urandom_range(1, 15);
      reg_rd(idx, v);
      total++;
      if (v !== mdl[idx]) $display("FAIL rand_reg%0d: got=%h required=%h", idx, v, mdl[idx]);
      else passed++;
    end
  endtask

  task automatic test_decode();
    logic [32:0] r;
    logic [31:0] v;
    int lat;
    bit held;
    afb(1'b1, 4'hF, 36'h100, 32'h0, 0, r, lat, held);
    total++;
    if (r !== {1'b1, 32'h0}) $display("FAIL decode_rd_err: got=%h required=100000000", r);
    else passed++;
    afb(1'b0, 4'hF, 36'h1_0000_0024, 32'h1234_5678, 0, r, lat, held);
    total++;
    if (r !== {1'b1, 32'h0}) $display("FAIL decode_wr_err: got=%h required=100000000", r);
    else passed++;
    reg_rd(9, v);
    total++;
    if (v !== mdl[9]) $display("FAIL decode_no_write: got=%h required=%h", v, mdl[9]);
    else passed++;
    afb(1'b1, 4'hF, 36'h3C, 32'h0, 0, r, lat, held);
    total++;
    if (r !== {1'b0, mdl[15]}) $display("FAIL top_index: got=%h required=0%h", r, mdl[15]);
    else passed++;
  endtask

  task automatic test_copy();
    logic [31:0] src, dst, v;
    int len;
    bit ie;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin src = 32'h1000; dst = 32'h2000; len = 3; ie = 1'b1; end
      else if (it == 1) begin src = 32'hFFFF_FFF3; dst = 32'h0000_4005; len = 3; ie = 1'b0; end
      else begin
        src = $urandom; dst = src ^ 32'h8000_0000;
        len = $urandom_range(1, 5); ie = 1'($urandom);
      end
      mem_stall = $urandom_range(0, 2);
      build_exp(src, dst, len, 1'b0, 64'h0);
      req_log.delete();
      reg_wr(2, src);
      reg_wr(3, dst);
      reg_wr(4, 32'(len));
      reg_wr(0, {29'h0, 1'b0, ie, 1'b1});
      wait_idle();
      total++;
      if (req_log.size() != exp_q.size())
        $display("FAIL copy%0d_count: got=%0d required=%0d", it, req_log.size(), exp_q.size());
      else passed++;
      foreach (exp_q[i]) if (i < req_log.size()) begin
        total++;
        if (req_log[i] !== exp_q[i])
          $display("FAIL copy%0d_txn%0d: got=%h required=%h", it, i, req_log[i], exp_q[i]);
        else passed++;
      end
      reg_rd(7, v);
      total++;
      if (v !== 32'(len)) $display("FAIL copy%0d_progress: got=%0d required=%0d", it, v, len);
      else passed++;
      reg_rd(1, v);
      total++;
      if (v !== 32'h2 || irq !== ie)
        $display("FAIL copy%0d_status: status=%h irq=%b required status=2 irq=%b", it, v, irq, ie);
      else passed++;
      reg_wr(1, 32'h2, 4'h1);
      @(negedge clk);
      reg_rd(1, v);
      total++;
      if (v !== 32'h0 || irq !== 1'b0)
        $display("FAIL copy%0d_w1c: status=%h irq=%b required status=0 irq=0", it, v, irq);
      else passed++;
    end
  endtask

  task automatic test_fill();
    logic [31:0] v;
    mem_stall = 4;
    build_exp(32'h0, 32'h3000, 2, 1'b1, 64'h1234_5678_9ABC_DEF0);
    req_log.delete();
    reg_wr(5, 32'h9ABC_DEF0);
    reg_wr(6, 32'h1234_5678);
    reg_wr(3, 32'h3000);
    reg_wr(4, 32'h0002_0002);
    reg_wr(0, 32'h5);
    wait_idle();
    total++;
    if (req_log.size() != exp_q.size())
      $display("FAIL fill_count: got=%0d required=%0d", req_log.size(), exp_q.size());
    else passed++;
    foreach (exp_q[i]) if (i < req_log.size()) begin
      total++;
      if (req_log[i] !== exp_q[i])
        $display("FAIL fill_txn%0d: got=%h required=%h", i, req_log[i], exp_q[i]);
      else passed++;
    end
    reg_rd(1, v);
    total++;
    if (v !== 32'h2 || irq !== 1'b0)
      $display("FAIL fill_status: status=%h irq=%b required status=2 irq=0", v, irq);
    else passed++;
    reg_wr(1, 32'h2, 4'h1);
  endtask

  task automatic test_error();
    logic [31:0] v;
    mem_stall = 6;
    err_at = 2;
    build_exp(32'h5000, 32'h6000, 1, 1'b0, 64'h0);
    exp_q.push_back('{rd: 1'b1, addr: 36'h5008, data: 64'h0});
    req_log.delete();
    reg_wr(2, 32'h5000);
    reg_wr(3, 32'h6000);
    reg_wr(4, 32'd4);
    reg_wr(0, 32'h3);
    reg_rd(1, v);
    total++;
    if (v[0] !== 1'b1) $display("FAIL err_busy: busy=%b required=1", v[0]);
    else passed++;
    reg_wr(4, 32'd7);
    reg_wr(0, 32'h3);
    wait_idle();
    err_at = -1;
    total++;
    if (req_log.size() != exp_q.size())
      $display("FAIL err_count: got=%0d required=%0d", req_log.size(), exp_q.size());
    else passed++;
    foreach (exp_q[i]) if (i < req_log.size()) begin
      total++;
      if (req_log[i] !== exp_q[i])
        $display("FAIL err_txn%0d: got=%h required=%h", i, req_log[i], exp_q[i]);
      else passed++;
    end
    reg_rd(1, v);
    total++;
    if (v !== 32'h4 || irq !== 1'b1)
      $display("FAIL err_status: status=%h irq=%b required status=4 irq=1", v, irq);
    else passed++;
    reg_rd(7, v);
    total++;
    if (v !== 32'd1) $display("FAIL err_progress: got=%0d required=1", v);
    else passed++;
    reg_rd(4, v);
    total++;
    if (v !== 32'd7) $display("FAIL busy_write_stored: got=%0d required=7", v);
    else passed++;
    reg_wr(1, 32'h4, 4'h1);
    req_log.delete();
    reg_wr(4, 32'h0001_0000);
    reg_wr(0, 32'h1);
    wait_idle();
    repeat (4) @(negedge clk);
    reg_rd(1, v);
    total++;
    if (v !== 32'h2 || req_log.size() != 0)
      $display("FAIL len0: status=%h txns=%0d required status=2 txns=0", v, req_log.size());
    else passed++;
    reg_wr(1, 32'h6, 4'h1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int n = 0;
    mem_stall = 0;
    hold_wr = 1'b1;
    req_log.delete();
    reg_wr(2, 32'h7000);
    reg_wr(3, 32'h8000);
    reg_wr(4, 32'd2);
    reg_wr(0, 32'h3);
    while (req_log.size() < 2 && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    total++;
    if (req_log.size() != 2 || mresp_ack !== 1'b1)
      $display("FAIL wr_wait_reached: txns=%0d ack=%b required txns=2 ack=1",
               req_log.size(), mresp_ack);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({afb_ack, rsp_vld, rsp_data, mreq_vld, mreq_data, mresp_ack, irq} !== '0)
      $display("FAIL midreset_outputs: ack=%b mvld=%b mrack=%b irq=%b required all 0",
               afb_ack, mreq_vld, mresp_ack, irq);
    else passed++;
    reset = 1'b0;
    hold_wr = 1'b0;
    repeat (2) @(negedge clk);
    stray_req = 1'b1;
    n = 0;
    while (stray_req && n < 100) begin @(negedge clk); n++; end
    if (stray_req) begin
      total++;
      $display("FAIL stray_timeout: pending=%b required=0", stray_req);
    end
    reg_rd(1, v);
    total++;
    if (v !== 32'h0 || irq !== 1'b0 || mreq_vld !== 1'b0)
      $display("FAIL stray_discard: status=%h irq=%b mvld=%b required 0 0 0", v, irq, mreq_vld);
    else passed++;
    reg_rd(7, v);
    total++;
    if (v !== 32'h0) $display("FAIL midreset_progress: got=%0d required=0", v);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_regfile();
    test_decode();
    test_copy();
    test_fill();
    test_error();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
